// File: rtl/trdb_pkg.sv
// trdb_pkg -- types and sizing shared by the trace debugger blocks.
// The branch map and the packet emitter both import this, so the map
// capacity and counter width are defined once, here.
//   MAP_LEN      : branch map capacity in bits
//   CNT_LEN      : width of the branch counter (2**CNT_LEN > MAP_LEN)
//   branch_map_t : a {map, count} pair as handed to the packet emitter
package trdb_pkg;

    localparam int MAP_LEN = 31;
    localparam int CNT_LEN = 5;

    typedef struct packed {
        logic [MAP_LEN-1:0] map;
        logic [CNT_LEN-1:0] count;
    } branch_map_t;

    // Combine a map and its count into the shared struct form.
    function automatic branch_map_t pack_branch_map(
        input logic [MAP_LEN-1:0] map,
        input logic [CNT_LEN-1:0] count
    );
        branch_map_t bm;
        bm.map   = map;
        bm.count = count;
        return bm;
    endfunction

endpackage

// File: rtl/trdb_branch_map_if.sv
// trdb_branch_map_if -- retirement/flush inputs and map/snapshot outputs
// of the branch map.
//   valid_i, is_branch_i, branch_taken_i : retired instruction info
//   flush_i                              : emitter consumed the map
//   map_o, branches_o                    : live map and its bit count
//   snap_map_o, snap_branches_o          : contents captured at last flush
//   snap_valid_o, overflow_o             : one-cycle event pulses
//   full_o, empty_o                      : counter decodes
// master drives the inputs (retire stage / emitter), slave is the map.
interface trdb_branch_map_if #(
    parameter int MAP_LEN = trdb_pkg::MAP_LEN,
    parameter int CNT_LEN = trdb_pkg::CNT_LEN
);
    logic               valid_i;
    logic               is_branch_i;
    logic               branch_taken_i;
    logic               flush_i;
    logic [MAP_LEN-1:0] map_o;
    logic [CNT_LEN-1:0] branches_o;
    logic [MAP_LEN-1:0] snap_map_o;
    logic [CNT_LEN-1:0] snap_branches_o;
    logic               snap_valid_o;
    logic               full_o;
    logic               empty_o;
    logic               overflow_o;

    modport master (
        output valid_i, is_branch_i, branch_taken_i, flush_i,
        input  map_o, branches_o, snap_map_o, snap_branches_o,
        input  snap_valid_o, full_o, empty_o, overflow_o
    );

    modport slave (
        input  valid_i, is_branch_i, branch_taken_i, flush_i,
        output map_o, branches_o, snap_map_o, snap_branches_o,
        output snap_valid_o, full_o, empty_o, overflow_o
    );
endinterface

// File: rtl/trdb_branch_map.sv
// trdb_branch_map -- accumulates conditional-branch outcomes into a bit map
// (LSB oldest, 1 = not taken) until the packet emitter flushes it. On flush
// the current map and count are captured into snapshot registers.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bm    : trdb_branch_map_if.slave (inputs, map, snapshot, pulses, flags)
module trdb_branch_map
    import trdb_pkg::*;
#(
    parameter int MAP_LEN = trdb_pkg::MAP_LEN,
    parameter int CNT_LEN = trdb_pkg::CNT_LEN
) (
    input logic               clk_i,
    input logic               rst_i,
    trdb_branch_map_if.slave  bm
);

    localparam logic [CNT_LEN-1:0] CNT_FULL = CNT_LEN'(MAP_LEN);
    localparam logic [CNT_LEN-1:0] CNT_ONE  = CNT_LEN'(1);

    logic [MAP_LEN-1:0] map_q,       map_n;
    logic [CNT_LEN-1:0] cnt_q,       cnt_n;
    logic [MAP_LEN-1:0] snap_map_q,  snap_map_n;
    logic [CNT_LEN-1:0] snap_cnt_q,  snap_cnt_n;
    logic               snap_vld_q,  snap_vld_n;
    logic               ovf_q,       ovf_n;

    logic branch_ev;
    logic full;

    assign branch_ev = bm.valid_i & bm.is_branch_i;
    assign full      = (cnt_q == CNT_FULL);

    always_comb begin
        map_n      = map_q;
        cnt_n      = cnt_q;
        snap_map_n = snap_map_q;
        snap_cnt_n = snap_cnt_q;
        snap_vld_n = 1'b0;
        ovf_n      = 1'b0;

        if (bm.flush_i) begin
            // Snapshot takes the pre-edge map; a same-cycle branch starts
            // the fresh map rather than landing in the flushed one.
            snap_map_n = map_q;
            snap_cnt_n = cnt_q;
            snap_vld_n = 1'b1;
            map_n      = '0;
            cnt_n      = '0;
            if (branch_ev) begin
                map_n[0] = ~bm.branch_taken_i;
                cnt_n    = CNT_ONE;
            end
        end else if (branch_ev) begin
            if (full) begin
                ovf_n = 1'b1;
            end else begin
                map_n[cnt_q] = ~bm.branch_taken_i;
                cnt_n        = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            map_q      <= '0;
            cnt_q      <= '0;
            snap_map_q <= '0;
            snap_cnt_q <= '0;
            snap_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            map_q      <= map_n;
            cnt_q      <= cnt_n;
            snap_map_q <= snap_map_n;
            snap_cnt_q <= snap_cnt_n;
            snap_vld_q <= snap_vld_n;
            ovf_q      <= ovf_n;
        end
    end

    assign bm.map_o           = map_q;
    assign bm.branches_o      = cnt_q;
    assign bm.snap_map_o      = snap_map_q;
    assign bm.snap_branches_o = snap_cnt_q;
    assign bm.snap_valid_o    = snap_vld_q;
    assign bm.overflow_o      = ovf_q;
    assign bm.full_o          = full;
    assign bm.empty_o         = (cnt_q == '0);

endmodule

// File: tb/tb_trdb_branch_map.sv
module tb_trdb_branch_map;
    import trdb_pkg::*;

    localparam int ML = MAP_LEN;
    localparam int CL = CNT_LEN;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    trdb_branch_map_if #(.MAP_LEN(ML), .CNT_LEN(CL)) bm_if ();

    trdb_branch_map #(.MAP_LEN(ML), .CNT_LEN(CL)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bm    (bm_if.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the live map is a queue of recorded bits, oldest first.
    bit          mq[$];
    logic [31:0] m_snap_map;
    int          m_snap_cnt;
    bit          m_snap_vld;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] q2map();
        logic [31:0] m = '0;
        foreach (mq[i]) m[i] = mq[i];
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_snap_map = '0;
        m_snap_cnt = 0;
        m_snap_vld = 0;
        m_ovf      = 0;
    endtask

    task automatic model_edge(input bit v, input bit b, input bit t, input bit f);
        bit ev = v && b;
        m_snap_vld = 0;
        m_ovf      = 0;
        if (f) begin
            m_snap_map = q2map();
            m_snap_cnt = mq.size();
            m_snap_vld = 1;
            mq.delete();
            if (ev) mq.push_back(!t);
        end else if (ev) begin
            if (mq.size() == ML) m_ovf = 1;
            else mq.push_back(!t);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".map"},       32'(bm_if.map_o),           q2map());
        chk({tag, ".branches"},  32'(bm_if.branches_o),      32'(mq.size()));
        chk({tag, ".snap_map"},  32'(bm_if.snap_map_o),      m_snap_map);
        chk({tag, ".snap_cnt"},  32'(bm_if.snap_branches_o), 32'(m_snap_cnt));
        chk({tag, ".snap_vld"},  32'(bm_if.snap_valid_o),    32'(m_snap_vld));
        chk({tag, ".overflow"},  32'(bm_if.overflow_o),      32'(m_ovf));
        chk({tag, ".full"},      32'(bm_if.full_o),          32'(mq.size() == ML));
        chk({tag, ".empty"},     32'(bm_if.empty_o),         32'(mq.size() == 0));
    endtask

    task automatic step(input string tag, input bit v, input bit b, input bit t, input bit f);
        bm_if.valid_i        = v;
        bm_if.is_branch_i    = b;
        bm_if.branch_taken_i = t;
        bm_if.flush_i        = f;
        @(posedge clk_i);
        model_edge(v, b, t, f);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        rst_i                = 1'b1;
        bm_if.valid_i        = 1'b0;
        bm_if.is_branch_i    = 1'b0;
        bm_if.branch_taken_i = 1'b0;
        bm_if.flush_i        = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // taken, not-taken, taken -> ...010
        step("tnt0", 1, 1, 1, 0);
        step("tnt1", 1, 1, 0, 0);
        step("tnt2", 1, 1, 1, 0);
        chk("tnt.map_literal", 32'(bm_if.map_o), 32'h2);
        step("clr0", 0, 0, 0, 1);

        // fill with not-taken, then one more overflows
        for (int i = 0; i < ML; i++) step("fill", 1, 1, 0, 0);
        chk("fill.all_ones", 32'(bm_if.map_o), 32'h7fff_ffff);
        step("ovf", 1, 1, 1, 0);
        step("ovf_idle", 0, 0, 0, 0);

        // flush together with a not-taken branch while full
        step("flush_br", 1, 1, 0, 1);
        chk("flush_br.literal", 32'(bm_if.map_o), 32'h1);
        step("clr1", 0, 0, 0, 1);

        // five branches then a lone flush
        for (int i = 0; i < 5; i++) step("five", 1, 1, 1'($urandom_range(1)), 0);
        step("five_flush", 0, 0, 0, 1);
        step("five_after", 0, 0, 0, 0);
        step("empty_flush", 0, 0, 0, 1);

        // branches interleaved with non-branch and idle cycles
        step("il0", 1, 1, 0, 0);
        step("il1", 1, 0, 0, 0);
        step("il2", 0, 1, 0, 0);
        step("il3", 0, 0, 1, 0);
        step("il4", 1, 0, 1, 0);
        step("il5", 1, 1, 0, 0);
        chk("il.count_ones", 32'($countones(bm_if.map_o)), 32'd2);
        step("clr2", 0, 0, 0, 1);

        // async reset mid-accumulation
        for (int i = 0; i < 7; i++) step("pre_rst", 1, 1, 1'($urandom_range(1)), 0);
        #3;
        rst_i = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk_i);
        #1;
        check_all("rst_hold");
        @(negedge clk_i);
        rst_i = 1'b0;
        step("post_rst_idle", 0, 0, 0, 0);
        step("post_rst_br", 1, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step("rand", 1'($urandom_range(7) != 0), 1'($urandom_range(3) != 0),
                 1'($urandom_range(1)), 1'($urandom_range(39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trdb_branch_map.md
TRDB_BRANCH_MAP -- requirements
Module: trdb_branch_map

Interface
REQ-001 Parameter MAP_LEN, default 31 (from package): branch map capacity in bits.
REQ-002 Parameter CNT_LEN, default 5 (from package): width of the branch counter; 2**CNT_LEN > MAP_LEN.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 valid_i  in  1  one retired instruction this cycle.
REQ-006 is_branch_i  in  1  the retired instruction is a conditional branch; ignored when valid_i=0.
REQ-007 branch_taken_i  in  1  the branch was taken; ignored unless valid_i&is_branch_i.
REQ-008 flush_i  in  1  the packet emitter consumed the map this cycle (branch_map_flush from the emitter).
REQ-009 map_o  out  MAP_LEN  live branch map; bit i is the i-th recorded branch, LSB oldest; 1 = not taken.
REQ-010 branches_o  out  CNT_LEN  number of valid bits in map_o (0..MAP_LEN).
REQ-011 snap_map_o  out  MAP_LEN  map contents captured at the last flush.
REQ-012 snap_branches_o  out  CNT_LEN  count captured at the last flush.
REQ-013 snap_valid_o  out  1  one-cycle pulse: the snapshot outputs were updated on the previous edge.
REQ-014 full_o  out  1  branches_o == MAP_LEN.
REQ-015 empty_o  out  1  branches_o == 0.
REQ-016 overflow_o  out  1  one-cycle pulse: a branch arrived while full without flush and was dropped.

Function
REQ-017 A branch event is valid_i & is_branch_i; no other inputs change state except flush_i.
REQ-018 A branch event with flush_i=0 and not full: on the next edge, map[branches] <= ~branch_taken_i and branches <= branches+1.
REQ-019 flush_i=1 with no branch event: on the next edge, snap_map <= map, snap_branches <= branches, snap_valid pulses, map <= 0, branches <= 0.
REQ-020 flush_i=1 with a branch event in the same cycle: the snapshot excludes the new branch; map <= {0.., ~branch_taken_i}, branches <= 1.
REQ-021 A branch event while full with flush_i=0: map and branches unchanged; overflow_o pulses for one cycle on the next edge.
REQ-022 flush_i while empty is legal: the snapshot captures 0/0 and snap_valid_o still pulses.
REQ-023 Map bits at index >= branches are always 0.
REQ-024 map_o, branches_o, snap_* and the pulses are registered, with one-cycle latency from the triggering input.
REQ-025 full_o and empty_o are combinational decodes of the branch counter; they carry no extra latency.
REQ-026 The counter never exceeds MAP_LEN and never wraps.
REQ-027 Non-branch valid instructions, and cycles with valid_i=0, hold all state; the pulses deassert.

Reset
REQ-028 On rst_i assertion, asynchronously: map_o=0, branches_o=0, snap_map_o=0, snap_branches_o=0, snap_valid_o=0, overflow_o=0; hence full_o=0 and empty_o=1.
REQ-029 Reset asserted mid-accumulation discards the map; no snapshot is produced.
REQ-030 The first edge after deassertion processes inputs normally.

Structure
REQ-031 MAP_LEN, CNT_LEN and a branch-map struct type {map, count} live in trdb_pkg, shared with trdb_packet_emitter.
REQ-032 Single module with no sub-modules; the counter and map update form one always_ff block with the next-state computed combinationally.

Verification
REQ-033 After reset, branches taken, not-taken, taken (3 events) -> map_o=...010, branches_o=3, empty_o=0.
REQ-034 31 not-taken branches -> map_o=all ones, branches_o=31, full_o=1; a 32nd branch -> overflow_o pulses for 1 cycle and the state is unchanged.
REQ-035 5 branches, then flush_i alone -> snap_branches_o=5, snap_map_o equals the prior map, snap_valid_o pulses once, map_o=0, empty_o=1.
REQ-036 Full map, then flush_i together with a not-taken branch -> snap_branches_o=31, branches_o=1, map_o=...001, no overflow.
REQ-037 Interleaved non-branch valid_i and idle cycles between 2 branches -> branches_o=2, and only 2 map bits are ever set.
REQ-038 rst_i asserted asynchronously between clock edges while branches_o=7 -> all outputs clear immediately, and no snap_valid_o pulse follows.
